// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared widths and result-source encodings for the writeback stage
package wb_pkg;
  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10,
    RES_FPX = 2'b11
  } res_src_e;
endpackage

// File: rtl/ll_result_fifo.sv
// rtl/ll_result_fifo.sv - in-order queue of {rd, data} long-latency results
module ll_result_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int W     = 32,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = PW + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [REG_AW-1:0] push_rd,
  input  logic [W-1:0]      push_data,
  input  logic              pop,
  output logic [REG_AW-1:0] head_rd,
  output logic [W-1:0]      head_data,
  output logic              full,
  output logic              empty,
  output logic [CW-1:0]     count
);
  logic [REG_AW-1:0] rd_mem   [DEPTH];
  logic [W-1:0]      data_mem [DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;

  // Power-of-two depth lets the pointers wrap on natural overflow.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      rd_mem[wr_ptr]   <= push_rd;
      data_mem[wr_ptr] <= push_data;
    end
  end

  assign head_rd   = rd_mem[rd_ptr];
  assign head_data = data_mem[rd_ptr];
  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);
endmodule

// File: rtl/wb_commit_arbiter.sv
// rtl/wb_commit_arbiter.sv - writeback port arbiter merging pipeline and long-latency results
module wb_commit_arbiter
  import wb_pkg::*;
#(
  parameter int XLEN_P       = XLEN,
  parameter int LQ_DEPTH     = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              RegWriteW,
  input  logic [1:0]        ResultSrcW,
  input  logic [REG_AW-1:0] RdW,
  input  logic [XLEN_P-1:0] ALUResultW,
  input  logic [XLEN_P-1:0] ReadDataW,
  input  logic [XLEN_P-1:0] PCPlus4W,
  input  logic [XLEN_P-1:0] FPXResultW,
  input  logic              ll_issue,
  input  logic [REG_AW-1:0] ll_issue_rd,
  input  logic              ll_valid,
  input  logic [REG_AW-1:0] ll_rd,
  input  logic [XLEN_P-1:0] ll_data,
  output logic              ll_ready,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [XLEN_P-1:0] rf_wdata,
  output logic [31:0]       pending,
  output logic              wb_bubble_req
);
  localparam int CW = $clog2(LQ_DEPTH) + 1;
  localparam int AW = $clog2(STARVE_LIMIT + 1);

  logic [XLEN_P-1:0] result_w;
  logic              pipe_wr, accept, bypass, q_pop, push, blocked;
  logic              ll_commit;
  logic [REG_AW-1:0] commit_rd, head_rd;
  logic [XLEN_P-1:0] commit_data, head_data;
  logic              full, empty;
  logic [CW-1:0]     count;
  logic [AW-1:0]     age;
  logic [31:0]       pending_nxt;

  always_comb begin
    case (res_src_e'(ResultSrcW))
      RES_ALU: result_w = ALUResultW;
      RES_MEM: result_w = ReadDataW;
      RES_PC4: result_w = PCPlus4W;
      default: result_w = FPXResultW;
    endcase
  end

  assign pipe_wr  = RegWriteW & (RdW != '0);
  assign ll_ready = ~reset & ~full;
  assign accept   = ll_valid & ll_ready;
  assign q_pop    = ~pipe_wr & ~empty;
  assign bypass   = ~pipe_wr & empty & accept;
  assign push     = accept & ~bypass;
  assign blocked  = pipe_wr & ~empty;

  assign ll_commit   = q_pop | bypass;
  assign commit_rd   = q_pop ? head_rd : ll_rd;
  assign commit_data = q_pop ? head_data : ll_data;

  ll_result_fifo #(.DEPTH(LQ_DEPTH), .W(XLEN_P)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_rd   (ll_rd),
    .push_data (ll_data),
    .pop       (q_pop),
    .head_rd   (head_rd),
    .head_data (head_data),
    .full      (full),
    .empty     (empty),
    .count     (count)
  );

  // rd 0 results are drained from the queue but never reach the register file.
  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = '0;
    rf_wdata = '0;
    if (!reset) begin
      if (pipe_wr) begin
        rf_we    = 1'b1;
        rf_waddr = RdW;
        rf_wdata = result_w;
      end else if (ll_commit) begin
        rf_we    = (commit_rd != '0);
        rf_waddr = commit_rd;
        rf_wdata = commit_data;
      end
    end
  end

  // Issue is applied after the clear so a same-cycle reissue of rd stays pending.
  always_comb begin
    pending_nxt = pending;
    if (ll_commit) pending_nxt[commit_rd] = 1'b0;
    if (ll_issue && ll_issue_rd != '0) pending_nxt[ll_issue_rd] = 1'b1;
    pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      age           <= '0;
      pending       <= '0;
      wb_bubble_req <= 1'b0;
    end else begin
      pending <= pending_nxt;
      if (empty || q_pop)                      age <= '0;
      else if (blocked && age != AW'(STARVE_LIMIT)) age <= age + 1'b1;
      wb_bubble_req <= (blocked && age >= AW'(STARVE_LIMIT - 1)) ||
                       (count == CW'(LQ_DEPTH) && pipe_wr);
    end
  end
endmodule

// File: tb/tb_wb_commit_arbiter.sv
// tb/tb_wb_commit_arbiter.sv - directed table and sequence bench for wb_commit_arbiter
module tb_wb_commit_arbiter;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        RegWriteW = 1'b0;
  logic [1:0]  ResultSrcW = 2'b00;
  logic [4:0]  RdW = '0;
  logic [31:0] ALUResultW = 32'h1111_1111;
  logic [31:0] ReadDataW  = 32'hDEAD_BEEF;
  logic [31:0] PCPlus4W   = 32'h0000_1004;
  logic [31:0] FPXResultW = 32'hCAFE_F00D;
  logic        ll_issue = 1'b0;
  logic [4:0]  ll_issue_rd = '0;
  logic        ll_valid = 1'b0;
  logic [4:0]  ll_rd = '0;
  logic [31:0] ll_data = '0;
  logic        ll_ready, rf_we, wb_bubble_req;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata, pending;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  wb_commit_arbiter dut (
    .clk(clk), .reset(reset), .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .RdW(RdW),
    .ALUResultW(ALUResultW), .ReadDataW(ReadDataW), .PCPlus4W(PCPlus4W), .FPXResultW(FPXResultW),
    .ll_issue(ll_issue), .ll_issue_rd(ll_issue_rd), .ll_valid(ll_valid), .ll_rd(ll_rd),
    .ll_data(ll_data), .ll_ready(ll_ready), .rf_we(rf_we), .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata), .pending(pending), .wb_bubble_req(wb_bubble_req)
  );

  typedef struct {
    logic        rw;
    logic [1:0]  src;
    logic [4:0]  rd;
    logic        llv;
    logic [4:0]  llrd;
    logic [31:0] lld;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
  } vec_t;

  vec_t vt[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic idle();
    RegWriteW = 1'b0; ResultSrcW = 2'b00; RdW = '0;
    ll_issue = 1'b0; ll_issue_rd = '0; ll_valid = 1'b0; ll_rd = '0; ll_data = '0;
  endtask

  task automatic issue(input logic [4:0] rd);
    ll_issue = 1'b1; ll_issue_rd = rd;
    next();
    ll_issue = 1'b0; ll_issue_rd = '0;
  endtask

  // Hazard-unit precondition: the pipeline never writes a register still awaiting a result.
  always @(negedge clk) begin
    if (!reset && RegWriteW && RdW != '0) chk("precond_pending_rd", {31'b0, pending[RdW]}, 32'h0);
  end

  initial begin
    vt[0] = '{1'b1, 2'b01, 5'd5,  1'b0, 5'd0, 32'h0,  1'b1, 5'd5,  32'hDEAD_BEEF};
    vt[1] = '{1'b1, 2'b00, 5'd6,  1'b0, 5'd0, 32'h0,  1'b1, 5'd6,  32'h1111_1111};
    vt[2] = '{1'b1, 2'b10, 5'd1,  1'b0, 5'd0, 32'h0,  1'b1, 5'd1,  32'h0000_1004};
    vt[3] = '{1'b1, 2'b11, 5'd31, 1'b0, 5'd0, 32'h0,  1'b1, 5'd31, 32'hCAFE_F00D};
    vt[4] = '{1'b0, 2'b00, 5'd5,  1'b0, 5'd0, 32'h0,  1'b0, 5'd0,  32'h0};
    vt[5] = '{1'b1, 2'b00, 5'd0,  1'b1, 5'd7, 32'h10, 1'b1, 5'd7,  32'h10};
    vt[6] = '{1'b0, 2'b00, 5'd0,  1'b1, 5'd0, 32'h5,  1'b0, 5'd0,  32'h0};
    vt[7] = '{1'b0, 2'b00, 5'd0,  1'b0, 5'd0, 32'h0,  1'b0, 5'd0,  32'h0};

    // Reset state, with pipeline inputs active
    RegWriteW = 1'b1; ResultSrcW = 2'b01; RdW = 5'd5; ll_valid = 1'b1; ll_rd = 5'd3;
    smp();
    chk("rst_rf_we", {31'b0, rf_we}, 32'h0);
    chk("rst_ll_ready", {31'b0, ll_ready}, 32'h0);
    chk("rst_pending", pending, 32'h0);
    chk("rst_bubble", {31'b0, wb_bubble_req}, 32'h0);
    next();
    reset = 1'b0;
    idle();

    issue(5'd7);
    smp();
    chk("pend_after_issue7", pending, 32'h0000_0080);
    next();

    for (int i = 0; i < 8; i++) begin
      RegWriteW = vt[i].rw; ResultSrcW = vt[i].src; RdW = vt[i].rd;
      ll_valid = vt[i].llv; ll_rd = vt[i].llrd; ll_data = vt[i].lld;
      smp();
      chk($sformatf("vec%0d_we", i), {31'b0, rf_we}, {31'b0, vt[i].we});
      chk($sformatf("vec%0d_ready", i), {31'b0, ll_ready}, 32'h1);
      if (vt[i].we) begin
        chk($sformatf("vec%0d_waddr", i), {27'b0, rf_waddr}, {27'b0, vt[i].wa});
        chk($sformatf("vec%0d_wdata", i), rf_wdata, vt[i].wd);
      end
      next();
      idle();
    end
    smp();
    chk("pend7_cleared_by_bypass", pending, 32'h0);
    next();

    // Two results queued behind three pipeline writes
    issue(5'd3);
    issue(5'd4);
    RegWriteW = 1'b1; RdW = 5'd5; ll_valid = 1'b1; ll_rd = 5'd3; ll_data = 32'h33;
    smp();
    chk("b2b_c1_ready", {31'b0, ll_ready}, 32'h1);
    chk("b2b_c1_waddr", {27'b0, rf_waddr}, 32'd5);
    next();
    ll_rd = 5'd4; ll_data = 32'h44;
    smp();
    chk("b2b_c2_ready", {31'b0, ll_ready}, 32'h1);
    next();
    ll_valid = 1'b0;
    smp();
    chk("b2b_c3_ready", {31'b0, ll_ready}, 32'h0);
    chk("b2b_c3_waddr", {27'b0, rf_waddr}, 32'd5);
    next();
    idle();
    smp();
    chk("b2b_c4_we", {31'b0, rf_we}, 32'h1);
    chk("b2b_c4_waddr", {27'b0, rf_waddr}, 32'd3);
    chk("b2b_c4_wdata", rf_wdata, 32'h33);
    chk("b2b_c4_bubble", {31'b0, wb_bubble_req}, 32'h1);
    next();
    smp();
    chk("b2b_c5_waddr", {27'b0, rf_waddr}, 32'd4);
    chk("b2b_c5_wdata", rf_wdata, 32'h44);
    chk("b2b_c5_bubble", {31'b0, wb_bubble_req}, 32'h0);
    chk("b2b_c5_ready", {31'b0, ll_ready}, 32'h1);
    next();
    smp();
    chk("b2b_c6_we", {31'b0, rf_we}, 32'h0);
    chk("b2b_c6_pending", pending, 32'h0);
    next();

    // Head starvation: one entry blocked four cycles
    RegWriteW = 1'b1; RdW = 5'd5; ll_valid = 1'b1; ll_rd = 5'd12; ll_data = 32'hC0;
    next();
    ll_valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      smp();
      chk($sformatf("starve_blk%0d_bubble", k), {31'b0, wb_bubble_req}, 32'h0);
      next();
    end
    RegWriteW = 1'b0;
    smp();
    chk("starve_bubble_set", {31'b0, wb_bubble_req}, 32'h1);
    chk("starve_head_we", {31'b0, rf_we}, 32'h1);
    chk("starve_head_waddr", {27'b0, rf_waddr}, 32'd12);
    chk("starve_head_wdata", rf_wdata, 32'hC0);
    next();
    idle();
    smp();
    chk("starve_bubble_clear", {31'b0, wb_bubble_req}, 32'h0);
    chk("starve_idle_we", {31'b0, rf_we}, 32'h0);
    next();

    // Scoreboard: same-cycle set and clear of rd 9, and rd 0 issue
    issue(5'd9);
    smp();
    chk("sb_pend9", pending, 32'h0000_0200);
    next();
    ll_issue = 1'b1; ll_issue_rd = 5'd9; ll_valid = 1'b1; ll_rd = 5'd9; ll_data = 32'h9;
    smp();
    chk("sb_bypass9_waddr", {27'b0, rf_waddr}, 32'd9);
    next();
    idle();
    smp();
    chk("sb_set_wins", pending, 32'h0000_0200);
    next();
    issue(5'd0);
    smp();
    chk("sb_rd0_never_set", pending, 32'h0000_0200);
    next();
    ll_valid = 1'b1; ll_rd = 5'd9; ll_data = 32'h99;
    next();
    idle();
    smp();
    chk("sb_pend9_cleared", pending, 32'h0);
    next();

    // Reset with two queued entries and pending bits 3 and 9
    issue(5'd3);
    issue(5'd9);
    RegWriteW = 1'b1; RdW = 5'd5; ll_valid = 1'b1; ll_rd = 5'd3; ll_data = 32'h3;
    next();
    ll_rd = 5'd9; ll_data = 32'h9;
    next();
    ll_valid = 1'b0;
    smp();
    chk("mid_pending", pending, 32'h0000_0208);
    chk("mid_full_ready", {31'b0, ll_ready}, 32'h0);
    #1 reset = 1'b1;
    #1;
    chk("mid_rst_we", {31'b0, rf_we}, 32'h0);
    chk("mid_rst_pending", pending, 32'h0);
    next();
    reset = 1'b0;
    idle();
    smp();
    chk("post_rst_ready", {31'b0, ll_ready}, 32'h1);
    chk("post_rst_we", {31'b0, rf_we}, 32'h0);
    chk("post_rst_bubble", {31'b0, wb_bubble_req}, 32'h0);
    next();
    smp();
    chk("post_rst_queue_empty_we", {31'b0, rf_we}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
